// File: rtl/layer15_out_collector_pkg.sv
// Shared types and defaults for the layer15 output collector.
// Word format, lane count and FSM state encoding live here.
package layer15_out_collector_pkg;

    localparam int FP_TOTAL_DEF = 16;
    localparam int FP_FRAC_DEF  = 0;
    localparam int NUM_OUT_DEF  = 5;
    localparam int CNT_W_DEF    = 16;
    localparam int IDX_W        = 3;

    typedef logic signed [FP_TOTAL_DEF-1:0] fixed_t;

    typedef enum logic [1:0] {
        COLLECT,
        SCAN,
        PRESENT
    } collect_state_t;

endpackage

// File: rtl/layer15_out_collector_if.sv
// Bundle of the per-lane AXI-stream inputs and the single result record port.
// slave = collector side, master = producer/consumer side.
interface layer15_out_collector_if #(
    parameter int FP_TOTAL = 16,
    parameter int NUM_OUT  = 5,
    parameter int CNT_W    = 16
);
    logic [NUM_OUT*FP_TOTAL-1:0] lane_TDATA;
    logic [NUM_OUT-1:0]          lane_TVALID;
    logic [NUM_OUT-1:0]          lane_TREADY;
    logic [NUM_OUT*FP_TOTAL-1:0] res_vec_TDATA;
    logic [2:0]                  res_argmax;
    logic [FP_TOTAL-1:0]         res_max;
    logic                        res_TVALID;
    logic                        res_TREADY;
    logic [CNT_W-1:0]            res_count;
    logic                        busy;

    modport slave (
        input  lane_TDATA, lane_TVALID, res_TREADY,
        output lane_TREADY, res_vec_TDATA, res_argmax, res_max, res_TVALID, res_count, busy
    );

    modport master (
        output lane_TDATA, lane_TVALID, res_TREADY,
        input  lane_TREADY, res_vec_TDATA, res_argmax, res_max, res_TVALID, res_count, busy
    );

endinterface

// File: rtl/layer15_out_collector_lane.sv
// One output lane: captures a single word and then stalls until cleared.
// Latency 1 edge to capture; TREADY low while captured, outside COLLECT, or in reset.
module layer15_out_collector_lane #(
    parameter int W = 16
) (
    input  logic         ap_clk,
    input  logic         ap_rst,
    input  logic [W-1:0] tdata_i,
    input  logic         tvalid_i,
    input  logic         collect_i,
    input  logic         clear_i,
    output logic         tready_o,
    output logic         fire_o,
    output logic         cap_o,
    output logic [W-1:0] data_o
);

    logic         cap_q;
    logic [W-1:0] data_q;

    assign tready_o = collect_i & ~cap_q & ~ap_rst;
    assign fire_o   = tvalid_i & tready_o;
    assign cap_o    = cap_q;
    assign data_o   = data_q;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            cap_q  <= 1'b0;
            data_q <= '0;
        end else if (fire_o) begin
            data_q <= tdata_i;
            cap_q  <= 1'b1;
        end else if (clear_i) begin
            cap_q  <= 1'b0;
        end
    end

endmodule

// File: rtl/layer15_out_collector.sv
// Collects one word per class lane, scans for the signed maximum, presents one record.
// Record valid NUM_OUT edges after last capture; lanes stall until the record is accepted.
module layer15_out_collector
    import layer15_out_collector_pkg::*;
#(
    parameter int FP_TOTAL = FP_TOTAL_DEF,
    parameter int NUM_OUT  = NUM_OUT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input logic                    ap_clk,
    input logic                    ap_rst,
    layer15_out_collector_if.slave io
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);

    collect_state_t              state_q;
    logic [IDX_W-1:0]            idx_q;
    logic signed [FP_TOTAL-1:0]  best_val_q, best_val_d, cur_val;
    logic [IDX_W-1:0]            best_idx_q, best_idx_d;
    logic                        res_vld_q;
    logic [NUM_OUT*FP_TOTAL-1:0] res_vec_q;
    logic [FP_TOTAL-1:0]         res_max_q;
    logic [IDX_W-1:0]            res_am_q;
    logic [CNT_W-1:0]            res_cnt_q;

    logic [NUM_OUT-1:0]          cap, fire, tready;
    logic [FP_TOTAL-1:0]         lane_reg [NUM_OUT];
    logic [NUM_OUT*FP_TOTAL-1:0] lane_flat;
    logic                        in_collect, accept;

    assign in_collect = (state_q == COLLECT);
    assign accept     = (state_q == PRESENT) & res_vld_q & io.res_TREADY;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
        layer15_out_collector_lane #(.W(FP_TOTAL)) u_lane (
            .ap_clk    (ap_clk),
            .ap_rst    (ap_rst),
            .tdata_i   (io.lane_TDATA[k*FP_TOTAL +: FP_TOTAL]),
            .tvalid_i  (io.lane_TVALID[k]),
            .collect_i (in_collect),
            .clear_i   (accept),
            .tready_o  (tready[k]),
            .fire_o    (fire[k]),
            .cap_o     (cap[k]),
            .data_o    (lane_reg[k])
        );
        assign lane_flat[k*FP_TOTAL +: FP_TOTAL] = lane_reg[k];
    end

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        cur_val    = lane_reg[idx_q];
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        if (idx_q == '0) begin
            best_val_d = cur_val;
            best_idx_d = '0;
        end else if (cur_val > best_val_q) begin
            best_val_d = cur_val;
            best_idx_d = idx_q;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= COLLECT;
            idx_q      <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            res_vld_q  <= 1'b0;
            res_vec_q  <= '0;
            res_max_q  <= '0;
            res_am_q   <= '0;
            res_cnt_q  <= '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (&(cap | fire)) begin
                        state_q <= SCAN;
                        idx_q   <= '0;
                    end
                end
                SCAN: begin
                    best_val_q <= best_val_d;
                    best_idx_q <= best_idx_d;
                    if (idx_q == LAST_IDX) begin
                        // Final compare result goes straight into the record.
                        idx_q     <= '0;
                        state_q   <= PRESENT;
                        res_vld_q <= 1'b1;
                        res_vec_q <= lane_flat;
                        res_max_q <= best_val_d;
                        res_am_q  <= best_idx_d;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                PRESENT: begin
                    if (res_vld_q && io.res_TREADY) begin
                        res_vld_q <= 1'b0;
                        res_cnt_q <= res_cnt_q + CNT_W'(1);
                        state_q   <= COLLECT;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign io.lane_TREADY   = tready;
    assign io.res_vec_TDATA = res_vec_q;
    assign io.res_argmax    = res_am_q;
    assign io.res_max       = res_max_q;
    assign io.res_TVALID    = res_vld_q;
    assign io.res_count     = res_cnt_q;
    assign io.busy          = (state_q != COLLECT) | (|cap);

endmodule

// File: tb/tb_layer15_out_collector.sv
// Scenario bench for layer15_out_collector with a queue-based record scoreboard.
module tb_layer15_out_collector;
    import layer15_out_collector_pkg::*;

    localparam int W  = 16;
    localparam int N  = 5;
    localparam int DW = W * N;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    layer15_out_collector_if #(.FP_TOTAL(W), .NUM_OUT(N), .CNT_W(16)) if_a ();
    layer15_out_collector_if #(.FP_TOTAL(W), .NUM_OUT(N), .CNT_W(4))  if_w ();

    layer15_out_collector #(.FP_TOTAL(W), .NUM_OUT(N), .CNT_W(16)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .io     (if_a.slave)
    );

    layer15_out_collector #(.FP_TOTAL(W), .NUM_OUT(N), .CNT_W(4)) dut_w (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .io     (if_w.slave)
    );

    typedef struct packed {
        logic [DW-1:0] vec;
        logic [2:0]    am;
        logic [W-1:0]  mx;
    } rec_t;

    rec_t sb[$];
    int   n_chk = 0;
    int   n_bad = 0;

    function automatic rec_t model(input logic [DW-1:0] v);
        rec_t r;
        logic signed [W-1:0] x;
        r.vec = v;
        r.am  = 3'd0;
        r.mx  = v[W-1:0];
        for (int k = 1; k < N; k++) begin
            x = v[k*W +: W];
            if (x > $signed(r.mx)) begin
                r.mx = x;
                r.am = 3'(k);
            end
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] pack5(input int a, input int b, input int c, input int d, input int e);
        return {W'(e), W'(d), W'(c), W'(b), W'(a)};
    endfunction

    function automatic logic [W-1:0] rnd_word();
        if ($urandom_range(0, 3) == 0) return W'($urandom_range(0, 3));
        return W'($urandom);
    endfunction

    task automatic apply_reset();
        @(negedge ap_clk);
        ap_rst = 1'b1;
        if_a.lane_TVALID = '0;
        if_a.res_TREADY  = 1'b0;
        if_w.lane_TVALID = '0;
        if_w.res_TREADY  = 1'b0;
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b0;
    endtask

    task automatic drive_rec(input logic [DW-1:0] data, input bit rnd, output bit ok);
        logic [N-1:0] pend, v, rdy;
        int guard;
        pend = '1;
        guard = 0;
        if_a.lane_TDATA = data;
        while (pend != '0 && guard < 3000) begin
            @(negedge ap_clk);
            for (int k = 0; k < N; k++) v[k] = pend[k] & (rnd ? 1'($urandom % 2) : 1'b1);
            if_a.lane_TVALID = v;
            rdy = if_a.lane_TREADY;
            @(posedge ap_clk);
            pend = pend & ~(v & rdy);
            guard++;
        end
        @(negedge ap_clk);
        if_a.lane_TVALID = '0;
        ok = (pend == '0);
    endtask

    task automatic wait_vld(output bit ok);
        int g;
        g = 0;
        @(negedge ap_clk);
        while (!if_a.res_TVALID && g < 100) begin
            @(negedge ap_clk);
            g++;
        end
        ok = if_a.res_TVALID;
    endtask

    task automatic test_reset();
        @(negedge ap_clk);
        ap_rst = 1'b1;
        if_a.lane_TVALID = '1;
        @(negedge ap_clk);
        n_chk++;
        if (if_a.lane_TREADY !== 5'h00) begin
            n_bad++; $display("FAIL rst_tready: got %h want 00", if_a.lane_TREADY);
        end
        n_chk++;
        if ({if_a.res_TVALID, if_a.busy, if_a.res_count, if_a.res_argmax, if_a.res_max, if_a.res_vec_TDATA} !== '0) begin
            n_bad++; $display("FAIL rst_outputs: got vld=%b busy=%b cnt=%h am=%h max=%h vec=%h want all 0",
                              if_a.res_TVALID, if_a.busy, if_a.res_count, if_a.res_argmax, if_a.res_max, if_a.res_vec_TDATA);
        end
        ap_rst = 1'b0;
        if_a.lane_TVALID = '0;
        @(negedge ap_clk);
        n_chk++;
        if (if_a.lane_TREADY !== 5'h1F || if_a.busy !== 1'b0) begin
            n_bad++; $display("FAIL post_rst_ready: got tready=%h busy=%b want 1f 0", if_a.lane_TREADY, if_a.busy);
        end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] d;
        int n;
        d = pack5(3, -7, 12, 12, 0);
        @(negedge ap_clk);
        if_a.lane_TDATA  = d;
        if_a.lane_TVALID = '1;
        if_a.res_TREADY  = 1'b1;
        n_chk++;
        if (if_a.lane_TREADY !== 5'h1F) begin
            n_bad++; $display("FAIL sim_ready_before: got %h want 1f", if_a.lane_TREADY);
        end
        @(posedge ap_clk);
        @(negedge ap_clk);
        if_a.lane_TVALID = '0;
        n_chk++;
        if (if_a.lane_TREADY !== 5'h00 || if_a.busy !== 1'b1) begin
            n_bad++; $display("FAIL sim_ready_after: got tready=%h busy=%b want 00 1", if_a.lane_TREADY, if_a.busy);
        end
        n = 0;
        while (!if_a.res_TVALID && n < 20) begin
            @(posedge ap_clk);
            n++;
            #1;
        end
        n_chk++;
        if (n !== 5) begin
            n_bad++; $display("FAIL sim_latency: got %0d edges want 5", n);
        end
        n_chk++;
        if (if_a.res_argmax !== 3'd2 || if_a.res_max !== 16'd12 || if_a.res_vec_TDATA !== d) begin
            n_bad++; $display("FAIL sim_record: got am=%0d max=%h vec=%h want am=2 max=000c vec=%h",
                              if_a.res_argmax, if_a.res_max, if_a.res_vec_TDATA, d);
        end
        @(posedge ap_clk);
        #1;
        n_chk++;
        if (if_a.res_TVALID !== 1'b0 || if_a.res_count !== 16'd1) begin
            n_bad++; $display("FAIL sim_accept: got vld=%b cnt=%0d want 0 1", if_a.res_TVALID, if_a.res_count);
        end
        @(negedge ap_clk);
        if_a.res_TREADY = 1'b0;
        n_chk++;
        if (if_a.lane_TREADY !== 5'h1F || if_a.busy !== 1'b0) begin
            n_bad++; $display("FAIL sim_reopen: got tready=%h busy=%b want 1f 0", if_a.lane_TREADY, if_a.busy);
        end
    endtask

    task automatic test_staggered();
        logic [DW-1:0] d;
        rec_t r;
        bit ok;
        int viol4;
        d = {16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h8000};
        sb.push_back(model(d));
        viol4 = 0;
        if_a.res_TREADY = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            @(negedge ap_clk);
            if_a.lane_TDATA[j*W +: W] = d[j*W +: W];
            if_a.lane_TVALID = 5'(1) << j;
            @(posedge ap_clk);
            @(negedge ap_clk);
            if_a.lane_TVALID = '0;
            n_chk++;
            if (if_a.lane_TREADY[j] !== 1'b0) begin
                n_bad++; $display("FAIL stag_cap_lane%0d: got tready=%b want 0", j, if_a.lane_TREADY[j]);
            end
            if (j > 0) begin
                repeat (9) begin
                    @(negedge ap_clk);
                    if (if_a.lane_TREADY[4] !== 1'b0) viol4++;
                end
            end
        end
        wait_vld(ok);
        n_chk++;
        if (!ok) begin
            n_bad++; $display("FAIL stag_timeout: got no valid want valid");
        end
        repeat (3) begin
            @(negedge ap_clk);
            if (if_a.lane_TREADY[4] !== 1'b0) viol4++;
        end
        r = sb.pop_front();
        n_chk++;
        if (if_a.res_argmax !== r.am || if_a.res_max !== r.mx || if_a.res_vec_TDATA !== r.vec) begin
            n_bad++; $display("FAIL stag_record: got am=%0d max=%h vec=%h want am=%0d max=%h vec=%h",
                              if_a.res_argmax, if_a.res_max, if_a.res_vec_TDATA, r.am, r.mx, r.vec);
        end
        if_a.res_TREADY = 1'b1;
        @(posedge ap_clk);
        #1;
        n_chk++;
        if (if_a.res_count !== 16'd2 || viol4 !== 0) begin
            n_bad++; $display("FAIL stag_accept: got cnt=%0d lane4_ready_cycles=%0d want 2 0", if_a.res_count, viol4);
        end
        @(negedge ap_clk);
        if_a.res_TREADY = 1'b0;
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] d1, d2;
        rec_t e, r;
        bit ok;
        int viol;
        d1 = pack5(100, -200, 300, -400, 50);
        d2 = pack5(-5, -6, -7, -8, -1);
        e = model(d1);
        sb.push_back(e);
        drive_rec(d1, 1'b0, ok);
        wait_vld(ok);
        n_chk++;
        if (!ok) begin
            n_bad++; $display("FAIL bp_timeout: got no valid want valid");
        end
        if_a.lane_TDATA  = d2;
        if_a.lane_TVALID = '1;
        viol = 0;
        repeat (200) begin
            @(negedge ap_clk);
            if (if_a.res_TVALID !== 1'b1 || if_a.lane_TREADY !== 5'h00 || if_a.busy !== 1'b1 ||
                if_a.res_vec_TDATA !== e.vec || if_a.res_argmax !== e.am || if_a.res_max !== e.mx) viol++;
        end
        n_chk++;
        if (viol !== 0) begin
            n_bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", viol);
        end
        r = sb.pop_front();
        n_chk++;
        if (if_a.res_argmax !== r.am || if_a.res_max !== r.mx || if_a.res_vec_TDATA !== r.vec) begin
            n_bad++; $display("FAIL bp_rec1: got am=%0d max=%h want am=%0d max=%h", if_a.res_argmax, if_a.res_max, r.am, r.mx);
        end
        if_a.res_TREADY = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        if_a.res_TREADY = 1'b0;
        n_chk++;
        if (if_a.res_TVALID !== 1'b0 || if_a.lane_TREADY !== 5'h1F) begin
            n_bad++; $display("FAIL bp_release: got vld=%b tready=%h want 0 1f", if_a.res_TVALID, if_a.lane_TREADY);
        end
        sb.push_back(model(d2));
        @(posedge ap_clk);
        @(negedge ap_clk);
        if_a.lane_TVALID = '0;
        wait_vld(ok);
        r = sb.pop_front();
        n_chk++;
        if (!ok || if_a.res_argmax !== r.am || if_a.res_max !== r.mx || if_a.res_vec_TDATA !== r.vec) begin
            n_bad++; $display("FAIL bp_rec2: got vld=%b am=%0d max=%h want 1 am=%0d max=%h",
                              ok, if_a.res_argmax, if_a.res_max, r.am, r.mx);
        end
        if_a.res_TREADY = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        if_a.res_TREADY = 1'b0;
        n_chk++;
        if (if_a.res_count !== 16'd4) begin
            n_bad++; $display("FAIL bp_count: got %0d want 4", if_a.res_count);
        end
    endtask

    task automatic test_mid_reset();
        logic [DW-1:0] d;
        rec_t r;
        bit ok;
        @(negedge ap_clk);
        if_a.lane_TDATA  = pack5(1, 2, 3, 0, 0);
        if_a.lane_TVALID = 5'b00111;
        @(posedge ap_clk);
        @(negedge ap_clk);
        if_a.lane_TVALID = '0;
        n_chk++;
        if (if_a.lane_TREADY !== 5'b11000 || if_a.busy !== 1'b1) begin
            n_bad++; $display("FAIL mr_partial: got tready=%h busy=%b want 18 1", if_a.lane_TREADY, if_a.busy);
        end
        ap_rst = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        n_chk++;
        if (if_a.lane_TREADY !== 5'h00) begin
            n_bad++; $display("FAIL mr_tready: got %h want 00", if_a.lane_TREADY);
        end
        n_chk++;
        if ({if_a.res_TVALID, if_a.busy, if_a.res_count, if_a.res_argmax, if_a.res_max, if_a.res_vec_TDATA} !== '0) begin
            n_bad++; $display("FAIL mr_outputs: got vld=%b busy=%b cnt=%0d want all 0", if_a.res_TVALID, if_a.busy, if_a.res_count);
        end
        ap_rst = 1'b0;
        @(negedge ap_clk);
        n_chk++;
        if (if_a.lane_TREADY !== 5'h1F) begin
            n_bad++; $display("FAIL mr_reopen: got %h want 1f", if_a.lane_TREADY);
        end
        d = pack5(-9, 4, 4, -2, 7);
        sb.push_back(model(d));
        drive_rec(d, 1'b0, ok);
        wait_vld(ok);
        r = sb.pop_front();
        n_chk++;
        if (!ok || if_a.res_argmax !== r.am || if_a.res_max !== r.mx || if_a.res_vec_TDATA !== r.vec) begin
            n_bad++; $display("FAIL mr_record: got am=%0d max=%h vec=%h want am=%0d max=%h vec=%h",
                              if_a.res_argmax, if_a.res_max, if_a.res_vec_TDATA, r.am, r.mx, r.vec);
        end
        if_a.res_TREADY = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        if_a.res_TREADY = 1'b0;
        n_chk++;
        if (if_a.res_count !== 16'd1) begin
            n_bad++; $display("FAIL mr_count: got %0d want 1", if_a.res_count);
        end
    endtask

    task automatic test_random();
        int got, idle, prod_to;
        apply_reset();
        got = 0;
        idle = 0;
        prod_to = 0;
        fork
            begin
                logic [DW-1:0] d;
                bit ok;
                for (int r = 0; r < 1000; r++) begin
                    for (int k = 0; k < N; k++) d[k*W +: W] = rnd_word();
                    sb.push_back(model(d));
                    drive_rec(d, 1'b1, ok);
                    if (!ok) prod_to++;
                end
            end
            begin
                logic rdy, vld;
                logic [DW-1:0] v;
                logic [2:0] am;
                logic [W-1:0] mx;
                rec_t e;
                while (got < 1000 && idle < 5000) begin
                    @(negedge ap_clk);
                    rdy = 1'($urandom % 2);
                    if_a.res_TREADY = rdy;
                    vld = if_a.res_TVALID;
                    v = if_a.res_vec_TDATA;
                    am = if_a.res_argmax;
                    mx = if_a.res_max;
                    @(posedge ap_clk);
                    if (vld && rdy) begin
                        got++;
                        idle = 0;
                        n_chk++;
                        if (sb.size() == 0) begin
                            n_bad++; $display("FAIL rnd_extra: got record %0d want none queued", got);
                        end else begin
                            e = sb.pop_front();
                            if (v !== e.vec || am !== e.am || mx !== e.mx) begin
                                n_bad++; $display("FAIL rnd_rec%0d: got am=%0d max=%h vec=%h want am=%0d max=%h vec=%h",
                                                  got, am, mx, v, e.am, e.mx, e.vec);
                            end
                        end
                    end else begin
                        idle++;
                    end
                end
                @(negedge ap_clk);
                if_a.res_TREADY = 1'b0;
            end
        join
        n_chk++;
        if (got !== 1000 || prod_to !== 0 || sb.size() !== 0) begin
            n_bad++; $display("FAIL rnd_flow: got recs=%0d prod_timeouts=%0d left=%0d want 1000 0 0", got, prod_to, sb.size());
        end
        n_chk++;
        if (if_a.res_count !== 16'd1000) begin
            n_bad++; $display("FAIL rnd_count: got %0d want 1000", if_a.res_count);
        end
    endtask

    task automatic test_wrap();
        int acc, g, rec_bad;
        logic [3:0] c16;
        bit taken;
        apply_reset();
        if_w.lane_TDATA  = pack5(1, 9, 2, 9, 3);
        if_w.lane_TVALID = '1;
        if_w.res_TREADY  = 1'b1;
        acc = 0;
        g = 0;
        rec_bad = 0;
        taken = 1'b0;
        c16 = 4'hF;
        while (acc < 17 && g < 2000) begin
            @(negedge ap_clk);
            g++;
            if (acc == 16 && !taken) begin
                c16 = if_w.res_count;
                taken = 1'b1;
            end
            if (if_w.res_TVALID) begin
                acc++;
                if (if_w.res_argmax !== 3'd1 || if_w.res_max !== 16'd9) rec_bad++;
                if (acc == 17) if_w.lane_TVALID = '0;
            end
        end
        @(negedge ap_clk);
        if_w.res_TREADY = 1'b0;
        n_chk++;
        if (acc !== 17 || rec_bad !== 0) begin
            n_bad++; $display("FAIL wrap_recs: got recs=%0d bad_recs=%0d want 17 0", acc, rec_bad);
        end
        n_chk++;
        if (c16 !== 4'd0) begin
            n_bad++; $display("FAIL wrap_at16: got %0d want 0", c16);
        end
        n_chk++;
        if (if_w.res_count !== 4'd1) begin
            n_bad++; $display("FAIL wrap_at17: got %0d want 1", if_w.res_count);
        end
        repeat (3) @(negedge ap_clk);
        n_chk++;
        if (if_w.busy !== 1'b0 || if_w.res_TVALID !== 1'b0) begin
            n_bad++; $display("FAIL wrap_idle: got busy=%b vld=%b want 0 0", if_w.busy, if_w.res_TVALID);
        end
    endtask

    initial begin
        if_a.lane_TDATA  = '0;
        if_a.lane_TVALID = '0;
        if_a.res_TREADY  = 1'b0;
        if_w.lane_TDATA  = '0;
        if_w.lane_TVALID = '0;
        if_w.res_TREADY  = 1'b0;
        apply_reset();
        test_reset();
        test_simultaneous();
        test_staggered();
        test_back_pressure();
        test_mid_reset();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
